// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings, arbitration mode constants and packed-slice helper
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational one-hot picker, round-robin from ptr or fixed lowest-index
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant
);

    int best;
    int d;

    // the requester with the smallest rotated distance from ptr wins
    always_comb begin
        grant = '0;
        best  = N;
        d     = 0;
        for (int i = 0; i < N; i++) begin
            d = mode ? (i + N - int'(ptr)) % N : i;
            if (req[i] && d < best) begin
                best     = d;
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahbl_rr_arbiter.sv
// ahbl_rr_arbiter: N-master to 1-slave AHB-Lite arbiter; losing address phases are buffered
// and their masters stalled, with fixed or round-robin priority and HMASTLOCK support.
module ahbl_rr_arbiter
    import ahbl_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int MODE      = MODE_RR
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [N_MASTERS*W_ADDR-1:0]   M_HADDR,
    input  logic [N_MASTERS*2-1:0]        M_HTRANS,
    input  logic [N_MASTERS*3-1:0]        M_HSIZE,
    input  logic [N_MASTERS-1:0]          M_HWRITE,
    input  logic [N_MASTERS-1:0]          M_HMASTLOCK,
    input  logic [N_MASTERS*W_DATA-1:0]   M_HWDATA,
    output logic [N_MASTERS-1:0]          M_HREADY,
    output logic [N_MASTERS*W_DATA-1:0]   M_HRDATA,
    output logic [W_ADDR-1:0]             S_HADDR,
    output logic [1:0]                    S_HTRANS,
    output logic [2:0]                    S_HSIZE,
    output logic                          S_HWRITE,
    output logic                          S_HMASTLOCK,
    output logic [W_DATA-1:0]             S_HWDATA,
    output logic                          S_HREADY,
    input  logic                          S_HREADYOUT,
    input  logic [W_DATA-1:0]             S_HRDATA,
    output logic [N_MASTERS-1:0]          GRANT
);

    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef logic [PW-1:0] idx_t;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic [1:0]        trans;
        logic [2:0]        size;
        logic              write;
        logic              lock;
    } ap_t;

    ap_t                 live_ap [N_MASTERS];
    ap_t                 pend_ap [N_MASTERS];
    ap_t                 sel;
    logic [W_DATA-1:0]   wdata   [N_MASTERS];
    logic [N_MASTERS-1:0] pending, live, req, pick, iss;
    idx_t                last_grant, ptr, gidx, d_owner;
    logic                d_valid, lock, show;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
        assign live_ap[i] = '{
            addr:  M_HADDR[slice_lo(i, W_ADDR) +: W_ADDR],
            trans: M_HTRANS[slice_lo(i, 2) +: 2],
            size:  M_HSIZE[slice_lo(i, 3) +: 3],
            write: M_HWRITE[i],
            lock:  M_HMASTLOCK[i]
        };
        assign wdata[i] = M_HWDATA[slice_lo(i, W_DATA) +: W_DATA];
        assign M_HRDATA[slice_lo(i, W_DATA) +: W_DATA] = S_HRDATA;
        assign M_HREADY[i] = pending[i] ? 1'b0 :
                             (d_valid && d_owner == idx_t'(i)) ? S_HREADYOUT : 1'b1;
        assign live[i] = M_HTRANS[2*i+1] & M_HREADY[i] & ~HRESET;
        assign GRANT[i] = (gidx == idx_t'(i));
    end

    assign req = pending | live;
    assign ptr = (last_grant == idx_t'(N_MASTERS - 1)) ? '0 : last_grant + 1'b1;

    rr_pick #(.N(N_MASTERS), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .mode  (MODE == MODE_RR),
        .grant (pick)
    );

    // a wait state, an active lock or an empty request set all keep the grant on last_grant
    always_comb begin
        gidx = last_grant;
        if (S_HREADYOUT && !lock && |req)
            for (int i = 0; i < N_MASTERS; i++)
                if (pick[i]) gidx = idx_t'(i);
    end

    assign sel         = pending[gidx] ? pend_ap[gidx] : live_ap[gidx];
    assign show        = pending[gidx] | (live_ap[gidx].trans[1] & ~HRESET) | lock;
    assign S_HADDR     = sel.addr;
    assign S_HTRANS    = show ? sel.trans : HTRANS_IDLE;
    assign S_HSIZE     = sel.size;
    assign S_HWRITE    = sel.write;
    assign S_HMASTLOCK = show & sel.lock;
    assign S_HWDATA    = wdata[d_owner];
    assign S_HREADY    = S_HREADYOUT;
    assign iss         = (S_HREADYOUT && S_HTRANS[1]) ? GRANT : '0;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pending    <= '0;
            d_valid    <= 1'b0;
            d_owner    <= '0;
            lock       <= 1'b0;
            last_grant <= idx_t'(N_MASTERS - 1);
        end else begin
            last_grant <= gidx;
            if (S_HREADYOUT) begin
                d_valid <= S_HTRANS[1];
                d_owner <= gidx;
                lock    <= S_HMASTLOCK;
            end
            for (int i = 0; i < N_MASTERS; i++)
                if (live[i] && !iss[i]) pending[i] <= 1'b1;
                else if (iss[i]) pending[i] <= 1'b0;
        end
    end

    always_ff @(posedge HCLK)
        for (int i = 0; i < N_MASTERS; i++)
            if (live[i] && !iss[i]) pend_ap[i] <= live_ap[i];

endmodule
